// File: rtl/imem_loader.sv
// imem_loader: collects a byte stream (most-significant byte first) into
// 32-bit instruction words and writes them to instruction memory, keeping
// the core held in reset until the requested number of words is written.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

  // Memory depth in words; a request longer than this is cut down to it.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_cnt;
  logic [1:0]      byte_cnt;
  logic [31:0]     shift;

  logic [ADDR_W:0] len_clamped;
  logic [ADDR_W:0] word_next;
  logic [31:0]     shift_next;

  // The word counter is one bit wider than waddr so a full-depth load can
  // reach the final count without wrapping back to zero.
  assign len_clamped = (len > DEPTH) ? DEPTH : len;
  assign word_next   = word_cnt + ONE;
  assign shift_next  = {shift[23:0], in_data};

  // Load sequencer: state, counters, shift register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len_q     <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      in_ready  <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      core_hold <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            len_q    <= len_clamped;
            word_cnt <= '0;
            byte_cnt <= '0;
            shift    <= '0;
            if (len != '0) begin
              state     <= LOAD;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              done      <= 1'b0;
              core_hold <= 1'b1;
            end else begin
              state     <= DONE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            shift    <= shift_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= COMMIT;
              in_ready <= 1'b0;
              we       <= 1'b1;
              waddr    <= word_cnt[ADDR_W-1:0];
              wdata    <= shift_next;
            end
          end
        end
        COMMIT: begin
          word_cnt <= word_next;
          if (word_next == len_q) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          core_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte streams against a behavioural loader model,
// plus a few fixed programs whose written words are known by hand.
module tb_imem_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   len = '0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          core_hold;
  logic          busy;
  logic          done;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .core_hold(core_hold), .busy(busy), .done(done)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      if (bad <= 40)
        $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: phases of a load, counted in whole bytes and words.
  localparam int P_IDLE = 0, P_LOAD = 1, P_COMMIT = 2, P_DONE = 3;
  int          m_phase = P_IDLE;
  int          m_target = 0;
  int          m_words = 0;
  int          m_bytes = 0;
  int          m_waddr = 0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_wdata = '0;

  // Advance the model on each edge from the inputs the DUT sees.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE;
      m_words = 0;
      m_bytes = 0;
      m_acc   = '0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start) begin
            m_target = (int'(len) > DEPTH) ? DEPTH : int'(len);
            m_words  = 0;
            m_bytes  = 0;
            m_acc    = '0;
            m_phase  = (m_target == 0) ? P_DONE : P_LOAD;
          end
        end
        P_LOAD: begin
          if (in_valid) begin
            m_acc = (m_acc << 8) | 32'(in_data);
            m_bytes++;
            if (m_bytes == 4) begin
              m_waddr = m_words;
              m_wdata = m_acc;
              m_bytes = 0;
              m_acc   = '0;
              m_phase = P_COMMIT;
            end
          end
        end
        default: begin
          m_words++;
          m_phase = (m_words == m_target) ? P_DONE : P_LOAD;
        end
      endcase
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("in_ready", 32'(in_ready), 32'(m_phase == P_LOAD));
    checkOutput("we", 32'(we), 32'(m_phase == P_COMMIT));
    checkOutput("core_hold", 32'(core_hold), 32'(m_phase != P_DONE));
    checkOutput("busy", 32'(busy), 32'(m_phase == P_LOAD || m_phase == P_COMMIT));
    checkOutput("done", 32'(done), 32'(m_phase == P_DONE));
    if (m_phase == P_COMMIT) begin
      checkOutput("waddr", 32'(waddr), 32'(m_waddr));
      checkOutput("wdata", wdata, m_wdata);
    end
  end

  // Record the writes the DUT actually issues.
  int          wr_count = 0;
  int          last_waddr = -1;
  logic [31:0] dut_mem [DEPTH];

  always @(negedge clk) begin
    if (we) begin
      wr_count++;
      dut_mem[waddr] = wdata;
      last_waddr = int'(waddr);
    end
  end

  logic [7:0] tx [$];

  // Pulse start, then stream the queued bytes; pct<0 toggles in_valid.
  task automatic applyStimulus(input int len_val, input int pct,
                               input bit noise, input bit wait_done);
    int budget;
    int n;
    bit tog;
    bit want;
    tog = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len = len_val[AW:0];
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    budget = tx.size() * 20 + 60;
    while (tx.size() > 0 && budget > 0) begin
      tog = ~tog;
      want = (pct < 0) ? tog : ($urandom_range(99) < pct);
      if (in_ready && want) begin
        in_valid = 1'b1;
        in_data = tx.pop_front();
      end else if (!in_ready) begin
        in_valid = 1'($urandom_range(1));
        in_data = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      start = noise && in_ready && ($urandom_range(3) == 0);
      len = (AW+1)'($urandom);
      @(negedge clk);
      budget--;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (budget == 0) checkOutput("feed_timeout", 32'd0, 32'd1);
    if (wait_done) begin
      n = 0;
      while (!done && n < 40) begin
        in_valid = !in_ready && ($urandom_range(1) == 1);
        in_data = 8'($urandom);
        @(negedge clk);
        n++;
      end
      in_valid = 1'b0;
      checkOutput("done_reached", 32'(done), 32'd1);
    end
  endtask

  logic [31:0] prog [6] = '{32'h02309020, 32'h02309022, 32'h02309024,
                            32'h02309025, 32'hAE720004, 32'h8E740004};

  initial begin
    logic [31:0] w;
    logic [31:0] exp_word;
    int          lr;
    int          nw;

    #1 rst = 1'b0;
    @(negedge clk);
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_we", 32'(we), 32'd0);
    checkOutput("rst_waddr", 32'(waddr), 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_core_hold", 32'(core_hold), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst = 1'b1;

    // Zero-length load from IDLE goes straight to DONE and frees the core.
    @(negedge clk);
    start = 1'b1;
    len = '0;
    @(negedge clk);
    start = 1'b0;
    #2;
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_core_hold", 32'(core_hold), 32'd0);
    checkOutput("zero_writes", 32'(wr_count), 32'd0);

    // Single word, in_valid held high.
    wr_count = 0;
    tx = '{8'h02, 8'h30, 8'h90, 8'h20};
    applyStimulus(1, 100, 1'b0, 1'b1);
    #2;
    checkOutput("one_writes", 32'(wr_count), 32'd1);
    checkOutput("one_word", dut_mem[0], 32'h02309020);
    checkOutput("one_core_hold", 32'(core_hold), 32'd0);

    // Six-word program with in_valid toggling every cycle.
    wr_count = 0;
    for (int i = 0; i < 6; i++) begin
      w = prog[i];
      for (int b = 3; b >= 0; b--) tx.push_back(w[8*b +: 8]);
    end
    applyStimulus(6, -1, 1'b0, 1'b1);
    #2;
    checkOutput("six_writes", 32'(wr_count), 32'd6);
    checkOutput("six_word2", dut_mem[2], 32'h02309024);
    checkOutput("six_word5", dut_mem[5], 32'h8E740004);
    checkOutput("six_last_addr", 32'(last_waddr), 32'd5);

    // Reset halfway through the second word.
    wr_count = 0;
    exp_word = '0;
    for (int i = 0; i < 6; i++) begin
      w[7:0] = 8'($urandom);
      tx.push_back(w[7:0]);
      if (i < 4) exp_word = exp_word * 256 + 32'(w[7:0]);
    end
    applyStimulus(2, 100, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    #2;
    checkOutput("mid_rst_core_hold", 32'(core_hold), 32'd1);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_writes", 32'(wr_count), 32'd1);
    checkOutput("mid_rst_word0", dut_mem[0], exp_word);
    rst = 1'b1;
    exp_word = '0;
    for (int i = 0; i < 4; i++) begin
      w[7:0] = 8'($urandom);
      tx.push_back(w[7:0]);
      exp_word = exp_word * 256 + 32'(w[7:0]);
    end
    applyStimulus(1, 70, 1'b1, 1'b1);
    #2;
    checkOutput("reload_writes", 32'(wr_count), 32'd2);
    checkOutput("reload_addr", 32'(last_waddr), 32'd0);
    checkOutput("reload_word0", dut_mem[0], exp_word);

    // Oversized length is cut to the memory depth.
    wr_count = 0;
    for (int i = 0; i < 4 * DEPTH; i++) tx.push_back(8'($urandom));
    applyStimulus(25, 70, 1'b1, 1'b1);
    #2;
    checkOutput("clamp_writes", 32'(wr_count), 32'(DEPTH));
    checkOutput("clamp_last_addr", 32'(last_waddr), 32'(DEPTH - 1));

    // Random loads, with stray start pulses and bytes outside LOAD.
    for (int k = 0; k < 8; k++) begin
      wr_count = 0;
      lr = $urandom_range(31);
      nw = (lr > DEPTH) ? DEPTH : lr;
      for (int i = 0; i < 4 * nw; i++) tx.push_back(8'($urandom));
      applyStimulus(lr, $urandom_range(30, 100), 1'b1, 1'b1);
      #2;
      checkOutput("rand_writes", 32'(wr_count), 32'(nw));
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
